// File: rtl/draw_pkg.sv
// Shared types and constants for the VGA layer-composition datapath.
package draw_pkg;

  typedef logic [7:0] rgb_t;

  localparam int   DEF_NUM_LAYERS  = 4;
  localparam rgb_t TRANSPARENT_RGB = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_t;

endpackage

// File: rtl/layer_flash_fsm.sv
// Frame-synchronous background flash sequencer: ON/OFF alternation for
// FLASH_FRAMES frames, with requests held pending until the FSM is idle.
module layer_flash_fsm
  import draw_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic flashReq,
  output logic flashOn,
  output logic flashActive
);

  flash_state_t state_q, state_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic         pending_q, pending_d;
  logic         active_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      pending_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      active_q    <= (state_d != IDLE);
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q | flashReq;
    unique case (state_q)
      IDLE: begin
        if (startOfFrame && (pending_q || flashReq)) begin
          state_d     = FLASH_ON;
          frame_cnt_d = 8'd0;
          pending_d   = 1'b0;
        end
      end
      FLASH_ON, FLASH_OFF: begin
        if (startOfFrame) begin
          if (frame_cnt_q == 8'(FLASH_FRAMES - 1)) begin
            state_d = IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flashOn     = (state_q == FLASH_ON);
    flashActive = active_q;
  end

endmodule

// File: rtl/draw_layer_arbiter.sv
// Per-pixel priority mux of object layers over the background, with
// frame-latched layer enables and a registered output toward the VGA stage.
module draw_layer_arbiter
  import draw_pkg::*;
#(
  parameter int   NUM_LAYERS      = DEF_NUM_LAYERS,
  parameter int   FLASH_FRAMES    = 8,
  parameter rgb_t FLASH_RGB       = 8'hE0,
  parameter rgb_t TRANSPARENT_RGB = draw_pkg::TRANSPARENT_RGB
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [NUM_LAYERS-1:0] layerDR,
  input  rgb_t [NUM_LAYERS-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0] layerEnable,
  input  rgb_t                  BG_RGB,
  input  logic                  flashReq,
  output rgb_t                  RGBOut,
  output logic [2:0]            winnerLayer,
  output logic                  flashActive
);

  logic [NUM_LAYERS-1:0] enable_q;
  logic                  flash_on;
  logic [2:0]            win_idx;
  rgb_t                  win_rgb;

  layer_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash_fsm (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .flashReq    (flashReq),
    .flashOn     (flash_on),
    .flashActive (flashActive)
  );

  // Scan from lowest priority upward so the lowest requesting index wins.
  always_comb begin
    win_idx = 3'(NUM_LAYERS);
    win_rgb = flash_on ? FLASH_RGB : BG_RGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layerDR[i] && enable_q[i] && (layerRGB[i] != TRANSPARENT_RGB)) begin
        win_idx = 3'(i);
        win_rgb = layerRGB[i];
      end
    end
  end

  // Enables only move at the frame boundary so a layer never tears mid-frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      enable_q    <= '1;
      RGBOut      <= 8'h00;
      winnerLayer <= 3'(NUM_LAYERS);
    end else begin
      if (startOfFrame) enable_q <= layerEnable;
      RGBOut      <= win_rgb;
      winnerLayer <= win_idx;
    end
  end

endmodule
